// File: rtl/sw_alloc_if.sv
// sw_alloc_if
// Bundles the signals that pass between one output-channel switch allocator,
// the rx ports that compete for that channel, and the downstream channel.
//
// Signals
//   sw_req    rx -> alloc   per-port allocation request
//   sw_chnl   rx -> alloc   per-port requested channel, port i at [i*CHANNEL_BITS +: CHANNEL_BITS]
//   sw_gnt    alloc -> rx   per-port grant, one-hot or zero
//   buf_addr  alloc -> rx   buffer read address broadcast to every rx buffer
//   buf_data  rx -> alloc   per-port combinational buffer read data, port i at [i*SIZE +: SIZE]
//   ch_req    alloc -> ch   two-phase (toggle) flit valid
//   ch_flit   alloc -> ch   flit payload
//   ch_ack    ch -> alloc   two-phase (toggle) flit acknowledge
//
// Modports
//   master    the allocator side
//   slave     the environment side (rx ports plus downstream channel)
interface sw_alloc_if #(
    parameter int PORTS        = 4,
    parameter int SIZE         = 8,
    parameter int BUFF_BITS    = 3,
    parameter int CHANNEL_BITS = 8
);
    logic [PORTS-1:0]              sw_req;
    logic [PORTS*CHANNEL_BITS-1:0] sw_chnl;
    logic [PORTS-1:0]              sw_gnt;
    logic [BUFF_BITS-1:0]          buf_addr;
    logic [PORTS*SIZE-1:0]         buf_data;
    logic                          ch_req;
    logic [SIZE-1:0]               ch_flit;
    logic                          ch_ack;

    modport master (
        input  sw_req, sw_chnl, buf_data, ch_ack,
        output sw_gnt, buf_addr, ch_req, ch_flit
    );

    modport slave (
        output sw_req, sw_chnl, buf_data, ch_ack,
        input  sw_gnt, buf_addr, ch_req, ch_flit
    );
endinterface

// File: rtl/sw_alloc.sv
// sw_alloc
// Switch allocator for one output channel. PORTS rx ports request the channel;
// a round-robin arbiter picks one eligible port (request high and requested
// channel equal to OUT_ID), grants it, then streams its FLITS-flit packet out
// of the rx buffer one flit at a time over a two-phase req/ack handshake.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous, active-high reset
//   bus        sw_alloc_if master modport (requests, grants, buffer read,
//              downstream toggle handshake)
//   busy       high whenever the allocator is not in IDLE
//   pkt_count  number of packets completed since reset, wraps at 16 bits
module sw_alloc #(
    parameter int PORTS        = 4,
    parameter int SIZE         = 8,
    parameter int BUFF_BITS    = 3,
    parameter int CHANNEL_BITS = 8,
    parameter int OUT_ID       = 0
) (
    input  logic              clk,
    input  logic              reset,
    sw_alloc_if.master        bus,
    output logic              busy,
    output logic [15:0]       pkt_count
);

    localparam int FLITS = 2 ** BUFF_BITS;
    localparam int PW    = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam logic [BUFF_BITS-1:0] LAST_FLIT = BUFF_BITS'(FLITS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        WAIT_ACK = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t               state;
    logic [PW-1:0]        winner;       // port owning the channel for this packet
    logic [PW-1:0]        last_winner;  // round-robin pointer: search starts after it
    logic [BUFF_BITS-1:0] flit_cnt;
    logic                 ack_q;        // ch_ack one cycle ago, for toggle detection

    logic                 ack_evt;
    logic [PORTS-1:0]     eligible;
    logic                 pick_found;
    logic [PW-1:0]        pick_idx;

    // Round-robin search: first eligible port starting at last+1, wrapping.
    // Returns {found, index}.
    function automatic logic [PW:0] rr_pick(
        input logic [PORTS-1:0] elig,
        input logic [PW-1:0]    last
    );
        logic          found;
        logic [PW-1:0] idx;
        int            p;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= PORTS; k++) begin
            p = (int'(last) + k) % PORTS;
            if (!found && elig[p]) begin
                found = 1'b1;
                idx   = PW'(p);
            end
        end
        return {found, idx};
    endfunction

    // A port only competes for this instance when it asks for our channel.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < PORTS; i++) begin
            eligible[i] = bus.sw_req[i] &&
                (bus.sw_chnl[i*CHANNEL_BITS +: CHANNEL_BITS] == CHANNEL_BITS'(OUT_ID));
        end
    end

    always_comb begin
        {pick_found, pick_idx} = rr_pick(eligible, last_winner);
    end

    // Two-phase acknowledge: any edge of ch_ack is one event.
    assign ack_evt = bus.ch_ack ^ ack_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            winner       <= '0;
            // Pointing at the last port makes port 0 the first one searched.
            last_winner  <= PW'(PORTS - 1);
            flit_cnt     <= '0;
            ack_q        <= 1'b0;
            busy         <= 1'b0;
            pkt_count    <= '0;
            bus.sw_gnt   <= '0;
            bus.buf_addr <= '0;
            bus.ch_req   <= 1'b0;
            bus.ch_flit  <= '0;
        end else begin
            ack_q <= bus.ch_ack;

            case (state)
                IDLE: begin
                    if (pick_found) begin
                        winner       <= pick_idx;
                        bus.sw_gnt   <= PORTS'(1) << pick_idx;
                        bus.buf_addr <= '0;
                        flit_cnt     <= '0;
                        busy         <= 1'b1;
                        state        <= LOAD;
                    end
                end

                // buf_addr was set on the previous edge, so the rx buffer's
                // combinational read data is already valid here.
                LOAD: begin
                    bus.ch_flit <= bus.buf_data[int'(winner)*SIZE +: SIZE];
                    bus.ch_req  <= ~bus.ch_req;
                    state       <= WAIT_ACK;
                end

                WAIT_ACK: begin
                    if (ack_evt) begin
                        if (flit_cnt == LAST_FLIT) begin
                            bus.sw_gnt  <= '0;
                            pkt_count   <= pkt_count + 16'd1;
                            last_winner <= winner;
                            state       <= DONE;
                        end else begin
                            flit_cnt     <= flit_cnt + 1'b1;
                            bus.buf_addr <= bus.buf_addr + 1'b1;
                            state        <= LOAD;
                        end
                    end
                end

                // One idle cycle so the rx port sees its grant drop before
                // any new arbitration takes place.
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_alloc.sv
// tb_sw_alloc
// Directed bench for sw_alloc: single packet, contention, fairness, wrong
// channel, backpressure with a spurious ack, and reset in mid-packet.
// A per-cycle task plays the rx ports (drop request on grant) and the
// downstream channel (toggle ack after a programmable delay).
module tb_sw_alloc;

    localparam int PORTS        = 4;
    localparam int SIZE         = 8;
    localparam int BUFF_BITS    = 3;
    localparam int CHANNEL_BITS = 8;
    localparam int OUT_ID       = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic [15:0] pkt_count;

    sw_alloc_if #(
        .PORTS(PORTS), .SIZE(SIZE), .BUFF_BITS(BUFF_BITS), .CHANNEL_BITS(CHANNEL_BITS)
    ) bus ();

    sw_alloc #(
        .PORTS(PORTS), .SIZE(SIZE), .BUFF_BITS(BUFF_BITS),
        .CHANNEL_BITS(CHANNEL_BITS), .OUT_ID(OUT_ID)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.master),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    // Buffer contents: port i, address a holds i*16 + a.
    always_comb begin
        for (int i = 0; i < PORTS; i++)
            bus.buf_data[i*SIZE +: SIZE] = SIZE'(i * 16) + SIZE'(bus.buf_addr);
    end

    int checks = 0;
    int errors = 0;

    int               pkts_left [PORTS];
    logic             seen;
    logic             pend;
    int               cnt;
    logic [SIZE-1:0]  held_flit;
    logic             held_req;
    int               flits_this_pkt;
    int               hold_flit = -1;
    int               hold_len  = 0;
    int               stable_err, multi_gnt, gnt_cycles, busy_seen, gnt_seen;
    logic [PORTS-1:0] gnt_prev;
    logic [PORTS-1:0] first_gnt;
    logic [BUFF_BITS-1:0] addr_at_grant;
    int               grant_order [$];
    logic [SIZE-1:0]  log_flit [$];
    int               log_port [$];
    int               exp_ports [$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [PORTS-1:0] v);
        for (int i = 0; i < PORTS; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    task automatic clear_logs();
        grant_order.delete();
        log_flit.delete();
        log_port.delete();
        stable_err = 0;
        multi_gnt  = 0;
        gnt_cycles = 0;
        busy_seen  = 0;
        gnt_seen   = 0;
        first_gnt  = '0;
    endtask

    // One clock: sample #1 after the edge, then act as monitor, channel and rx.
    task automatic tick();
        @(posedge clk);
        #1;
        // monitor
        if ($countones(bus.sw_gnt) > 1) multi_gnt++;
        if (bus.sw_gnt != '0) begin
            gnt_cycles++;
            gnt_seen++;
        end
        if (busy) busy_seen++;
        if (bus.sw_gnt != '0 && gnt_prev == '0) begin
            grant_order.push_back(onehot_idx(bus.sw_gnt));
            if (first_gnt == '0) first_gnt = bus.sw_gnt;
            addr_at_grant  = bus.buf_addr;
            flits_this_pkt = 0;
        end
        // downstream channel
        if (reset) begin
            seen = 1'b0;
            pend = 1'b0;
        end else if (bus.ch_req !== seen) begin
            seen      = bus.ch_req;
            held_flit = bus.ch_flit;
            held_req  = bus.ch_req;
            log_flit.push_back(bus.ch_flit);
            log_port.push_back(onehot_idx(bus.sw_gnt));
            cnt = (flits_this_pkt == hold_flit) ? hold_len : 0;
            flits_this_pkt++;
            if (cnt == 0) bus.ch_ack = ~bus.ch_ack;
            else          pend = 1'b1;
        end else if (pend) begin
            if (bus.ch_flit !== held_flit || bus.ch_req !== held_req) stable_err++;
            cnt--;
            if (cnt == 0) begin
                bus.ch_ack = ~bus.ch_ack;
                pend = 1'b0;
            end
        end
        // rx ports: drop the request once granted
        for (int i = 0; i < PORTS; i++) begin
            if (bus.sw_gnt[i] && !gnt_prev[i] && pkts_left[i] > 0) pkts_left[i]--;
            bus.sw_req[i] = (pkts_left[i] > 0) && !bus.sw_gnt[i];
        end
        gnt_prev = bus.sw_gnt;
    endtask

    task automatic wait_pkts(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (pkt_count != 16'(target) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(pkt_count), 32'(target));
    endtask

    task automatic set_exp(input int a, input int b, input int c, input int d);
        exp_ports.delete();
        if (a >= 0) exp_ports.push_back(a);
        if (b >= 0) exp_ports.push_back(b);
        if (c >= 0) exp_ports.push_back(c);
        if (d >= 0) exp_ports.push_back(d);
    endtask

    // Grant order and every flit against exp_ports.
    task automatic check_flits(input string tag);
        int bad;
        int ord_bad;
        int p;
        bad = 0;
        ord_bad = 0;
        check({tag, "_nflits"}, 32'(log_flit.size()), 32'(8 * exp_ports.size()));
        check({tag, "_ngrants"}, 32'(grant_order.size()), 32'(exp_ports.size()));
        for (int k = 0; k < grant_order.size() && k < exp_ports.size(); k++)
            if (grant_order[k] != exp_ports[k]) ord_bad++;
        for (int k = 0; k < log_flit.size() && k < 8 * exp_ports.size(); k++) begin
            p = exp_ports[k / 8];
            if (log_flit[k] !== SIZE'(p * 16 + (k % 8)) || log_port[k] != p) bad++;
        end
        check({tag, "_order"}, 32'(ord_bad), 0);
        check({tag, "_data"}, 32'(bad), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   32'(bus.sw_gnt),   0);
        check({tag, "_addr"},  32'(bus.buf_addr), 0);
        check({tag, "_req"},   32'(bus.ch_req),   0);
        check({tag, "_flit"},  32'(bus.ch_flit),  0);
        check({tag, "_busy"},  32'(busy),         0);
        check({tag, "_count"}, 32'(pkt_count),    0);
    endtask

    initial begin
        logic saved_req;
        int   n;

        reset       = 1'b1;
        bus.sw_req  = '0;
        bus.ch_ack  = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            bus.sw_chnl[i*CHANNEL_BITS +: CHANNEL_BITS] = CHANNEL_BITS'(OUT_ID);
            pkts_left[i] = 0;
        end
        seen = 1'b0;
        pend = 1'b0;
        cnt  = 0;
        held_flit = '0;
        held_req  = 1'b0;
        flits_this_pkt = 0;
        gnt_prev = '0;
        addr_at_grant = '0;
        clear_logs();

        // reset state
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // single request from port 2
        clear_logs();
        pkts_left[2] = 1;
        wait_pkts("single_count", 1, 200);
        check("single_gnt", 32'(first_gnt), 32'b0100);
        check("single_addr0", 32'(addr_at_grant), 0);
        check("single_gnt_cycles", 32'(gnt_cycles), 16);
        set_exp(2, -1, -1, -1);
        check_flits("single");
        tick();
        check("single_gnt_drop", 32'(bus.sw_gnt), 0);
        tick();

        // contention 0,1,3 from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        clear_logs();
        pkts_left[0] = 1;
        pkts_left[1] = 1;
        pkts_left[3] = 1;
        wait_pkts("contend_count", 3, 400);
        tick();
        tick();
        set_exp(0, 1, 3, -1);
        check_flits("contend");
        check("contend_onehot", 32'(multi_gnt), 0);

        // fairness: ports 0 and 1 each want two packets
        clear_logs();
        pkts_left[0] = 2;
        pkts_left[1] = 2;
        wait_pkts("fair_count", 7, 600);
        tick();
        tick();
        set_exp(0, 1, 0, 1);
        check_flits("fair");
        check("fair_onehot", 32'(multi_gnt), 0);

        // wrong channel on port 1
        bus.sw_chnl[1*CHANNEL_BITS +: CHANNEL_BITS] = CHANNEL_BITS'(OUT_ID + 1);
        clear_logs();
        pkts_left[1] = 1;
        for (int i = 0; i < 50; i++) tick();
        check("wrongch_busy", 32'(busy_seen), 0);
        check("wrongch_gnt", 32'(gnt_seen), 0);
        check("wrongch_count", 32'(pkt_count), 7);
        pkts_left[1] = 0;
        tick();
        bus.sw_chnl[1*CHANNEL_BITS +: CHANNEL_BITS] = CHANNEL_BITS'(OUT_ID);
        tick();

        // backpressure: ack for flit 3 held back 20 cycles
        clear_logs();
        hold_flit = 3;
        hold_len  = 20;
        pkts_left[3] = 1;
        wait_pkts("bp_count", 8, 400);
        check("bp_gnt_cycles", 32'(gnt_cycles), 36);
        check("bp_stable", 32'(stable_err), 0);
        set_exp(3, -1, -1, -1);
        check_flits("bp");
        hold_flit = -1;
        tick();
        tick();

        // spurious ack toggle while idle
        saved_req = bus.ch_req;
        clear_logs();
        bus.ch_ack = ~bus.ch_ack;
        for (int i = 0; i < 5; i++) tick();
        check("spur_busy", 32'(busy_seen), 0);
        check("spur_req", 32'(bus.ch_req), 32'(saved_req));
        check("spur_count", 32'(pkt_count), 8);
        clear_logs();
        pkts_left[0] = 1;
        wait_pkts("spur_next_count", 9, 200);
        set_exp(0, -1, -1, -1);
        check_flits("spur_next");
        tick();
        tick();

        // reset after flit 4 of a port 1 packet
        clear_logs();
        pkts_left[1] = 1;
        n = 0;
        while (log_flit.size() < 5 && n < 100) begin
            tick();
            n++;
        end
        check("mid_flits_before", 32'(log_flit.size()), 5);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        tick();
        tick();
        check("mid_req_held", 32'(bus.ch_req), 0);
        check("mid_flits_held", 32'(log_flit.size()), 5);
        reset = 1'b0;
        tick();
        clear_logs();
        pkts_left[0] = 1;
        pkts_left[2] = 1;
        wait_pkts("post_count", 2, 400);
        check("post_addr0", 32'(addr_at_grant), 0);
        set_exp(0, 2, -1, -1);
        check_flits("post");
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
